// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and opcode classification for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SRA   = 4'b0110;
    localparam logic [3:0] ALU_XOR   = 4'b0111;
    localparam logic [3:0] ALU_MUL   = 4'b1000;
    localparam logic [3:0] ALU_MULHU = 4'b1001;
    localparam logic [3:0] ALU_DIVU  = 4'b1010;
    localparam logic [3:0] ALU_REMU  = 4'b1011;

    typedef enum logic [1:0] {IDLE, MUL, DIV} alu_state_t;

    function automatic logic is_iterative(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Purely combinational single-cycle ALU covering the eight base operations.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        y = '0;
        unique case ({1'b0, op})
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLL: y = a << shamt;
            ALU_SRL: y = a >> shamt;
            ALU_SRA: y = $unsigned($signed(a) >>> shamt);
            ALU_XOR: y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle base ops plus iterative shift-add multiply and
// restoring divide, with a start/busy/done handshake and a held result register.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [3:0]       ALUControl,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Busy,
    output logic             Done
);

    localparam logic [SHW-1:0] last_cnt = SHW'(WIDTH - 1);

    alu_state_t         state_q;
    logic [SHW-1:0]     count_q;
    // MUL: {partial product, remaining multiplier}; DIV: {remainder, quotient}.
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic               hi_sel_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               done_q;

    logic [WIDTH-1:0]   comb_y;
    logic [WIDTH-1:0]   imm_res;
    logic               div_zero;
    logic               go_iter;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_r1;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] step_next;
    logic [WIDTH-1:0]   fin_word;

    alu_comb #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_comb (
        .a  (SrcA),
        .b  (SrcB),
        .op (ALUControl[2:0]),
        .y  (comb_y)
    );

    always_comb begin
        div_zero = (SrcB == '0);
        imm_res  = comb_y;
        if (ALUControl[3]) begin
            unique case (ALUControl)
                ALU_DIVU: imm_res = '1;
                ALU_REMU: imm_res = SrcA;
                default:  imm_res = '0;
            endcase
        end
        go_iter = is_iterative(ALUControl) && !(ALUControl[1] && div_zero);
    end

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q & {WIDTH{acc_q[0]}}};
        div_r1   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge   = div_r1 >= {1'b0, opnd_q};
        // The true difference is below the divisor, so WIDTH bits suffice.
        div_diff = div_r1[WIDTH-1:0] - opnd_q;
        if (state_q == MUL) begin
            step_next = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
            step_next = {div_ge ? div_diff : div_r1[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
        end
        fin_word = hi_sel_q ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            hi_sel_q <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (Start) begin
                        if (go_iter) begin
                            state_q  <= ALUControl[1] ? DIV : MUL;
                            count_q  <= '0;
                            hi_sel_q <= ALUControl[0];
                            opnd_q   <= ALUControl[1] ? SrcB : SrcA;
                            acc_q    <= {{WIDTH{1'b0}}, ALUControl[1] ? SrcA : SrcB};
                        end else begin
                            result_q <= imm_res;
                            zero_q   <= (imm_res == '0);
                            done_q   <= 1'b1;
                        end
                    end
                end
                MUL, DIV: begin
                    acc_q   <= step_next;
                    count_q <= count_q + 1'b1;
                    if (count_q == last_cnt) begin
                        result_q <= fin_word;
                        zero_q   <= (fin_word == '0);
                        done_q   <= 1'b1;
                        count_q  <= '0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign Busy      = (state_q != IDLE);
    assign Done      = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: cycle-level reference model plus directed vectors
// at WIDTH=32 and a second instance at WIDTH=8.
module tb_alu_mc;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst32, start32, busy32, done32, zero32;
    logic [3:0]  op32;
    logic [31:0] a32, b32, res32;
    logic        rst8, start8, busy8, done8, zero8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, res8;

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(32)) dut32 (
        .clk        (clk),
        .reset      (rst32),
        .Start      (start32),
        .SrcA       (a32),
        .SrcB       (b32),
        .ALUControl (op32),
        .ALUResult  (res32),
        .Zero       (zero32),
        .Busy       (busy32),
        .Done       (done32)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .reset      (rst8),
        .Start      (start8),
        .SrcA       (a8),
        .SrcB       (b8),
        .ALUControl (op8),
        .ALUResult  (res8),
        .Zero       (zero8),
        .Busy       (busy8),
        .Done       (done8)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Architectural result of one operation, from plain arithmetic.
    function automatic longint unsigned ref_alu(input logic [3:0] op, input longint unsigned a,
                                                input longint unsigned b, input int w);
        longint unsigned mask = (64'd1 << w) - 1;
        int              sh   = int'(b % longint'(w));
        longint unsigned r;
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a << sh;
            4'd5:    r = a >> sh;
            4'd6:    r = (a >> sh) | ((((a >> (w - 1)) & 1) != 0) ? (mask & ~(mask >> sh)) : 0);
            4'd7:    r = a ^ b;
            4'd8:    r = a * b;
            4'd9:    r = (a * b) >> w;
            4'd10:   r = (b == 0) ? mask : a / b;
            4'd11:   r = (b == 0) ? a : a % b;
            default: r = 0;
        endcase
        return r & mask;
    endfunction

    // Reference model for the 32-bit instance: a countdown to completion.
    logic        m_busy, m_done;
    logic [31:0] m_res, m_pend, m_r;
    int          m_left;

    always @(posedge clk or posedge rst32) begin
        if (rst32) begin
            m_busy = 1'b0; m_done = 1'b0; m_res = '0; m_pend = '0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_res = m_pend; m_done = 1'b1;
                end
            end else if (start32) begin
                m_r = 32'(ref_alu(op32, longint'(a32), longint'(b32), 32));
                if (op32 >= 4'd8 && op32 <= 4'd11 && !(op32 >= 4'd10 && b32 == 0)) begin
                    m_busy = 1'b1; m_left = 32; m_pend = m_r;
                end else begin
                    m_res = m_r; m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started && !rst32) begin
            chk("cycle busy", busy32, m_busy);
            chk("cycle done", done32, m_done);
            chk("cycle result", res32, m_res);
            chk("cycle zero", zero32, m_res == 0);
        end
    end

    // Issue one op, then count edges until Done; edges = 0 for single-cycle ops.
    task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int edges, input string nm);
        int n, nb;
        @(negedge clk);
        start32 = 1'b1; op32 = op; a32 = a; b32 = b;
        @(negedge clk);
        start32 = 1'b0; a32 = $urandom; b32 = $urandom; op32 = 4'($urandom);
        n = 1; nb = 0;
        while (!done32 && n <= edges + 4) begin
            if (busy32) nb++;
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, 64'(n), 64'(edges + 1));
        chk({nm, " busy cycles"}, 64'(nb), 64'(edges));
        chk({nm, " result"}, res32, exp);
        chk({nm, " zero"}, zero32, exp == 0);
    endtask

    initial begin
        int n, dn;
        logic [31:0] held;
        rst32 = 1'b1; start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        rst8  = 1'b1; start8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
        repeat (2) @(negedge clk);
        chk("reset result", res32, 32'h0);
        chk("reset zero", zero32, 1'b1);
        chk("reset busy", busy32, 1'b0);
        chk("reset done", done32, 1'b0);
        rst32 = 1'b0; rst8 = 1'b0;
        started = 1'b1;

        run32(ALU_ADD,   32'd5,          32'd7,          32'd12,         0,  "add");
        run32(ALU_SUB,   32'd7,          32'd7,          32'd0,          0,  "sub");
        run32(ALU_ADD,   32'hFFFF_FFFF,  32'd2,          32'd1,          0,  "add wrap");
        run32(ALU_SRA,   32'h8000_0000,  32'd4,          32'hF800_0000,  0,  "sra");
        run32(ALU_SRL,   32'h8000_0000,  32'd4,          32'h0800_0000,  0,  "srl");
        run32(ALU_SLL,   32'd1,          32'd31,         32'h8000_0000,  0,  "sll");
        run32(ALU_SLL,   32'd1,          32'h25,         32'h20,         0,  "sll low bits");
        run32(ALU_AND,   32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'h00F0_00F0,  0,  "and");
        run32(ALU_OR,    32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'hFFF0_FFF0,  0,  "or");
        run32(ALU_XOR,   32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'hFF00_FF00,  0,  "xor");
        run32(4'b1100,   32'd5,          32'd7,          32'd0,          0,  "reserved");
        run32(ALU_MUL,   32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  32, "mul");
        run32(ALU_MULHU, 32'hFFFF_FFFF,  32'd2,          32'h0000_0001,  32, "mulhu");
        run32(ALU_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32, "mulhu max");
        run32(ALU_DIVU,  32'd100,        32'd7,          32'd14,         32, "divu");
        run32(ALU_REMU,  32'd100,        32'd7,          32'd2,          32, "remu");
        run32(ALU_DIVU,  32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32, "divu by one");
        run32(ALU_REMU,  32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  32, "remu wide");
        run32(ALU_DIVU,  32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  0,  "divu by zero");
        run32(ALU_REMU,  32'd9,          32'd0,          32'd9,          0,  "remu by zero");

        // Back-to-back single-cycle ops.
        @(negedge clk);
        start32 = 1'b1; op32 = ALU_ADD; a32 = 32'd1; b32 = 32'd1;
        @(negedge clk);
        chk("b2b first", res32, 32'd2);
        chk("b2b first done", done32, 1'b1);
        a32 = 32'd2; b32 = 32'd2;
        @(negedge clk);
        start32 = 1'b0;
        chk("b2b second", res32, 32'd4);
        chk("b2b second done", done32, 1'b1);

        // Start during a multiply is ignored.
        @(negedge clk);
        start32 = 1'b1; op32 = ALU_MUL; a32 = 32'd3; b32 = 32'd5;
        @(negedge clk);
        start32 = 1'b0;
        repeat (5) @(negedge clk);
        start32 = 1'b1; op32 = ALU_ADD; a32 = 32'd1; b32 = 32'd1;
        @(negedge clk);
        start32 = 1'b0;
        dn = 0;
        repeat (40) begin
            if (done32) dn++;
            @(negedge clk);
        end
        chk("ignored start dones", 64'(dn), 64'd1);
        chk("ignored start result", res32, 32'd15);

        // Asynchronous reset ten cycles into a divide.
        @(negedge clk);
        start32 = 1'b1; op32 = ALU_DIVU; a32 = 32'd1000; b32 = 32'd3;
        @(negedge clk);
        start32 = 1'b0;
        repeat (10) @(negedge clk);
        held = res32;
        chk("pre-reset result held", held, 32'd15);
        #2 rst32 = 1'b1;
        #1;
        chk("async reset result", res32, 32'h0);
        chk("async reset zero", zero32, 1'b1);
        chk("async reset busy", busy32, 1'b0);
        chk("async reset done", done32, 1'b0);
        @(negedge clk);
        rst32 = 1'b0;
        dn = 0;
        repeat (40) begin
            if (done32) dn++;
            @(negedge clk);
        end
        chk("aborted op dones", 64'(dn), 64'd0);

        // WIDTH=8 instance.
        @(negedge clk);
        start8 = 1'b1; op8 = ALU_MUL; a8 = 8'd15; b8 = 8'd17;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'hAA; b8 = 8'h55;
        n = 1;
        while (!done8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("w8 mul latency", 64'(n), 64'd9);
        chk("w8 mul result", res8, 8'hFF);
        chk("w8 mul zero", zero8, 1'b0);
        @(negedge clk);
        start8 = 1'b1; op8 = ALU_MULHU; a8 = 8'd15; b8 = 8'd17;
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 20) begin
            chk("w8 mulhu busy", busy8, 1'b1);
            @(negedge clk);
            n++;
        end
        chk("w8 mulhu latency", 64'(n), 64'd9);
        chk("w8 mulhu result", res8, 8'h00);
        chk("w8 mulhu zero", zero8, 1'b1);

        started = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, width-parametrised ALU for the next processor datapath. It keeps the eight single-cycle ALU operations, which complete in one clock. It adds unsigned multiply (low and high word) and unsigned divide/remainder, computed iteratively at one bit per clock. A start/busy/done handshake lets the control unit stall the pipeline while an iterative operation runs; the result is registered and held until the next completion.

## Interface
- `WIDTH`, 32, operand and result width in bits; must be at least 8.
- `SHW`, `$clog2(WIDTH)`, derived shift-amount width; never overridden.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `Start`  in  1  request; accepted on a rising edge only when `Busy`=0.
- `SrcA`  in  WIDTH  operand A; sampled at accept.
- `SrcB`  in  WIDTH  operand B; sampled at accept.
- `ALUControl`  in  4  operation code; sampled at accept.
- `ALUResult`  out  WIDTH  registered result; holds its value between completions.
- `Zero`  out  1  registered; equals (`ALUResult`==0).
- `Busy`  out  1  iterative operation in progress.
- `Done`  out  1  one-cycle pulse in the cycle `ALUResult` becomes valid.

## Operation
- Opcodes 0000–0111 are single-cycle:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR.
  - 0100 SLL by `SrcB[SHW-1:0]`.
  - 0101 SRL (logical right shift).
  - 0110 SRA (arithmetic right shift, signed).
  - 0111 XOR.
- Opcodes 1000–1011 are iterative:
  - 1000 MUL: low WIDTH bits of the unsigned product.
  - 1001 MULHU: high WIDTH bits of the unsigned product.
  - 1010 DIVU: unsigned quotient.
  - 1011 REMU: unsigned remainder.
- Opcodes 11xx are reserved: single-cycle, result 0.
- ADD/SUB wrap modulo 2^WIDTH; no carry or overflow flags.
- Divide by zero (`SrcB`=0 with DIVU/REMU) takes the single-cycle path. DIVU returns all-ones; REMU returns `SrcA`.
- FSM states: IDLE, MUL, DIV.
  - IDLE, accept of a single-cycle op or divide by zero: write result, pulse `Done`, stay in IDLE.
  - IDLE, accept of MUL/MULHU: load the 2·WIDTH accumulator and multiplier, clear the counter, go to MUL.
  - IDLE, accept of DIVU/REMU: load remainder=0, quotient=`SrcA`, divisor=`SrcB`, clear the counter, go to DIV.
  - MUL: shift-add one bit per cycle.
  - DIV: restoring divide, one bit per cycle.
  - MUL/DIV, counter = WIDTH-1: complete the final iteration, write the selected half/word to `ALUResult`, pulse `Done`, return to IDLE.
- `Start` while `Busy`=1 is ignored. It is not queued, and the operands in flight are unaffected.
- Operand inputs may change freely after accept.
- Reset, including mid-operation: state IDLE, `ALUResult`=0, `Zero`=1, `Busy`=0, `Done`=0, counter and datapath registers 0. An aborted operation produces no `Done`.

## Timing
- Single-cycle op accepted at edge N: `ALUResult` and `Done`=1 are visible after edge N; `Done` clears after edge N+1 unless a new op completes then.
- Iterative op accepted at edge N:
  - `Busy`=1 after edges N through N+WIDTH-1.
  - After edge N+WIDTH: `Busy`=0, `Done`=1, result valid.
  - Latency is WIDTH cycles.
- A new `Start` may be accepted in the same cycle `Done` is high, since `Busy` is already 0. This gives back-to-back single-cycle throughput of one op per clock.
- `Zero` always tracks the registered `ALUResult`; it is never derived from inputs.

## Structure
- Package `alu_pkg`: opcode localparams (`ALU_ADD` … `ALU_REMU`), state enum `alu_state_t` {IDLE, MUL, DIV}, and an `is_iterative(op)` helper function.
- One sub-module, `alu_comb`: purely combinational, WIDTH-parametrised, covering the eight base operations. `alu_mc` instantiates it and owns the FSM, counter, iterative datapath and result register.

## Test plan
- WIDTH=32, ADD 5+7 -> `ALUResult`=12, `Done` one cycle after `Start`, `Busy` never high, `Zero`=0. Then SUB 7-7 -> 0, `Zero`=1.
- SRA 0x8000_0000 by 4 -> 0xF800_0000. SRL of the same -> 0x0800_0000. SLL 1 by 31 -> 0x8000_0000.
- MUL 0xFFFF_FFFF×2 -> 0xFFFF_FFFE; MULHU of the same -> 0x0000_0001. `Busy` high for exactly 32 cycles, `Done` after edge N+32.
- DIVU 100/7 -> 14 and REMU -> 2, each with 32-cycle latency. DIVU x/0 -> 0xFFFF_FFFF and REMU 9/0 -> 9, each in 1 cycle.
- Pulse `Start` with ADD while a MUL is busy -> ignored; the MUL result is unaffected and only one `Done` occurs.
- Assert `reset` 10 cycles into a DIVU -> all outputs take reset values immediately (async), with no `Done`. Then rerun with WIDTH=8: MUL 15×17 -> 0xFF with 8-cycle latency.
